// File: rtl/mem_bus_if.sv
// Bus bundle between the CPU memory port, the boot ROM and main RAM.
// The controller uses the slave modport; the CPU plus memory side uses master.
interface mem_bus_if;
  // Handshakes: the CPU raises cpu_rd or cpu_wr, which is sampled only while
  // cpu_busy is low. The controller answers with a single-cycle cpu_done
  // pulse, and cpu_rdata is valid during it. Toward RAM, ram_rd or ram_wr is
  // held high, with ram_addr and ram_wdata stable, until ram_ack is sampled
  // high. ram_rdata is valid together with ram_ack.
  logic [14:0] cpu_addr;
  logic [11:0] cpu_wdata;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [11:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_busy;
  logic        bus_err;
  logic [14:0] rom_addr;
  logic        rom_rd;
  logic [11:0] rom_data;
  logic        rom_selected;
  logic [14:0] ram_addr;
  logic [11:0] ram_wdata;
  logic        ram_rd;
  logic        ram_wr;
  logic [11:0] ram_rdata;
  logic        ram_ack;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr, rom_data, rom_selected,
           ram_rdata, ram_ack,
    output cpu_rdata, cpu_done, cpu_busy, bus_err, rom_addr, rom_rd,
           ram_addr, ram_wdata, ram_rd, ram_wr
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_rd, cpu_wr, rom_data, rom_selected,
           ram_rdata, ram_ack,
    input  cpu_rdata, cpu_done, cpu_busy, bus_err, rom_addr, rom_rd,
           ram_addr, ram_wdata, ram_rd, ram_wr
  );
endinterface

// File: rtl/mem_bus_ctl.sv
// Memory bus controller: routes each CPU cycle to the boot ROM or to RAM, and applies a RAM ack timeout.
// Defining ROM_WRITE_TRAP_EN turns writes to a selected ROM address into a bus error instead of a shadow-RAM write.
module mem_bus_ctl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    mem_bus_if.slave    bus,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        RAM   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] counter;
    logic       is_wr;

    assign bus.cpu_busy = (state != IDLE);
    assign dbg_state    = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            counter       <= 8'd0;
            is_wr         <= 1'b0;
            bus.bus_err   <= 1'b0;
            bus.cpu_rdata <= 12'd0;
            bus.cpu_done  <= 1'b0;
            bus.rom_rd    <= 1'b0;
            bus.ram_rd    <= 1'b0;
            bus.ram_wr    <= 1'b0;
            bus.rom_addr  <= 15'd0;
            bus.ram_addr  <= 15'd0;
            bus.ram_wdata <= 12'd0;
        end else begin
            bus.cpu_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cpu_rd && bus.cpu_wr) begin
                        bus.bus_err <= 1'b1;
                    end else if (bus.cpu_rd ^ bus.cpu_wr) begin
                        is_wr         <= bus.cpu_wr;
                        bus.rom_addr  <= bus.cpu_addr;
                        bus.ram_addr  <= bus.cpu_addr;
                        bus.ram_wdata <= bus.cpu_wdata;
                        // Only reads strobe the ROM, so its fetch-triggered logic sees one strobe per fetch.
                        bus.rom_rd    <= bus.cpu_rd;
                        state         <= PROBE;
                    end
                end
                PROBE: begin
                    bus.rom_rd <= 1'b0;
                    if (bus.rom_selected && !is_wr) begin
                        bus.cpu_rdata <= bus.rom_data;
                        bus.cpu_done  <= 1'b1;
                        state         <= DONE;
                    end
`ifdef ROM_WRITE_TRAP_EN
                    else if (bus.rom_selected && is_wr) begin
                        bus.bus_err  <= 1'b1;
                        bus.cpu_done <= 1'b1;
                        state        <= DONE;
                    end
`endif
                    else begin
                        counter    <= 8'(TIMEOUT);
                        bus.ram_rd <= !is_wr;
                        bus.ram_wr <= is_wr;
                        state      <= RAM;
                    end
                end
                RAM: begin
                    // An ack in the final counting cycle takes priority over the timeout.
                    if (bus.ram_ack) begin
                        if (!is_wr) bus.cpu_rdata <= bus.ram_rdata;
                        bus.ram_rd   <= 1'b0;
                        bus.ram_wr   <= 1'b0;
                        bus.cpu_done <= 1'b1;
                        counter      <= 8'd0;
                        state        <= DONE;
                    end else if (counter <= 8'd1) begin
                        bus.bus_err   <= 1'b1;
                        bus.cpu_rdata <= 12'o7777;
                        bus.ram_rd    <= 1'b0;
                        bus.ram_wr    <= 1'b0;
                        bus.cpu_done  <= 1'b1;
                        counter       <= 8'd0;
                        state         <= DONE;
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_bus_ctl.md
# mem_bus_ctl

Memory bus controller between the CPU memory port and the two memory targets: the 7400–7577 boot ROM window and main RAM. It latches each CPU read or write, probes the boot ROM, and routes the cycle to either the ROM or RAM. It runs a request/acknowledge handshake toward RAM, with a timeout, and returns data to the CPU with a one-cycle completion strobe.

## Interface
Parameters:
- TIMEOUT, default 15: maximum number of cycles to wait for `ram_ack` before the cycle is aborted (legal range 1–255).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `cpu_addr`  in  15  CPU address (field + 12-bit address)
- `cpu_wdata`  in  12  CPU write data
- `cpu_rd`  in  1  read request, sampled in IDLE
- `cpu_wr`  in  1  write request, sampled in IDLE
- `cpu_rdata`  out  12  read data; valid when `cpu_done` is high
- `cpu_done`  out  1  one-cycle completion pulse
- `cpu_busy`  out  1  high in every state except IDLE
- `bus_err`  out  1  sticky error flag; cleared only by reset
- `rom_addr`  out  15  address to the boot ROM
- `rom_rd`  out  1  ROM read strobe
- `rom_data`  in  12  ROM data
- `rom_selected`  in  1  ROM claims the current address
- `ram_addr`  out  15  RAM address
- `ram_wdata`  out  12  RAM write data
- `ram_rd`  out  1  RAM read request
- `ram_wr`  out  1  RAM write request
- `ram_rdata`  in  12  RAM read data, valid together with `ram_ack`
- `ram_ack`  in  1  RAM completion

## Operation
- **State machine:** IDLE → PROBE → {RAM, DONE} → DONE → IDLE.
- **IDLE**
  - If `cpu_rd` xor `cpu_wr` is high: latch `cpu_addr`, `cpu_wdata` and the direction, then go to PROBE.
  - If `cpu_rd` and `cpu_wr` are both high: set `bus_err`, stay in IDLE, and raise no `cpu_done`.
- **PROBE** (exactly one cycle)
  - `rom_addr` is driven from the latched address.
  - `rom_rd` is high only for reads, so the ROM's fetch-triggered deactivate logic sees exactly one strobe per CPU fetch.
  - Read with `rom_selected` = 1: register `rom_data` into `cpu_rdata`, then go to DONE.
  - Write with `rom_selected` = 1: see Configuration.
  - Otherwise: load the timeout counter with TIMEOUT and go to RAM.
- **RAM**
  - `ram_rd` or `ram_wr` is held high, with `ram_addr` and `ram_wdata` stable, until `ram_ack` is sampled high.
  - On ack: a read registers `ram_rdata` into `cpu_rdata`; go to DONE.
  - The counter decrements each cycle without ack. Reaching 0 without ack sets `bus_err`, sets `cpu_rdata` = 7777 (octal), and goes to DONE.
  - An ack arriving in the same cycle the counter reaches 0 wins: the cycle completes normally.
- **DONE:** `cpu_done` = 1 for one cycle, then return to IDLE. `cpu_rdata` holds its value until the next completed read.
- When `rom_rd` is low, `rom_addr` still follows the latched address. `ram_addr` and `ram_wdata` always reflect the latched values.
- A spurious `ram_ack` outside the RAM state is ignored.

## Timing
- **Reset values** (reset overrides all state in any cycle, including mid-RAM cycle):
  - state = IDLE, counter = 0, `bus_err` = 0
  - `cpu_rdata` = 0000, `cpu_done` = 0, `cpu_busy` = 0
  - `rom_rd` = 0, `ram_rd` = 0, `ram_wr` = 0
  - `rom_addr` = `ram_addr` = 0, `ram_wdata` = 0
- **ROM read:** request sampled at edge 0; PROBE in cycle 1; `cpu_done` high in cycle 2. Latency is 2 cycles.
- **RAM access:** RAM request high from cycle 2. If ack is sampled at the end of cycle k, `cpu_done` is high in cycle k+1. Minimum latency is 3 cycles, with ack in cycle 2.
- **Timeout:** `cpu_done` comes TIMEOUT+2 cycles after the request.
- Requests asserted while `cpu_busy` = 1 are ignored. The CPU must re-assert after `cpu_done`; the earliest new request is sampled in the cycle after DONE.
- All outputs are registered, except `cpu_busy`, which decodes the state.

## Configuration
- **`ROM_WRITE_TRAP_EN` defined:** a write in PROBE with `rom_selected` = 1 is discarded. No RAM access occurs; `bus_err` is set; the controller goes straight to DONE.
- **`ROM_WRITE_TRAP_EN` undefined:** such writes fall through to RAM (shadow-RAM behaviour) exactly like unselected addresses, and `bus_err` is not set.

## Test plan
- **ROM read:** `rom_selected` = 1, `rom_data` = 7240, read 07400 → `rom_rd` high for exactly one cycle; `cpu_done` 2 cycles after the request with `cpu_rdata` = 7240.
- **RAM read:** `rom_selected` = 0, read 00200, `ram_ack` after 3 cycles with `ram_rdata` = 1234 → `ram_rd` stays high until ack; `cpu_rdata` = 1234; `cpu_done` in the cycle after ack.
- **RAM write:** write 5555 to 10017 → `ram_wr` is high with `ram_addr` = 10017 and `ram_wdata` = 5555 until ack; `bus_err` stays 0.
- **Timeout:** TIMEOUT = 4, no ack → `cpu_done` 6 cycles after the request, `cpu_rdata` = 7777, `bus_err` = 1. Variant: ack in the final counting cycle → normal completion with no error.
- **ROM-window write:** `rom_selected` = 1, write to 07410 → with `ROM_WRITE_TRAP_EN`: no `ram_wr`, `bus_err` = 1, `cpu_done` in cycle 2. Without it: `ram_wr` is issued and `bus_err` = 0.
- **Reset and illegal request:** assert reset while in RAM → next cycle `ram_rd` = 0 and state is IDLE. Separately, `cpu_rd` and `cpu_wr` high together → `bus_err` = 1, `cpu_busy` stays 0.
